// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC ownership, IF/ID pairing, stall, redirect and delivered count
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [31:0]            BranchTarget,
  input  logic                   Jump,
  input  logic [31:0]            JumpTarget,
  input  logic [31:0]            InstIn,
  output logic [31:0]            Pc,
  output logic [31:0]            IfId_Inst,
  output logic [31:0]            IfId_Pc,
  output logic [31:0]            IfId_PcPlus4,
  output logic                   IfId_Valid,
  output logic [COUNT_WIDTH-1:0] FetchCount
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]            pc_reg;
  logic [31:0]            pc_tag;
  logic                   valid;
  logic [COUNT_WIDTH-1:0] cnt;

  logic                   redirect;
  logic [31:0]            target_raw;
  logic [31:0]            target;
  logic                   accept;

  assign redirect   = Jump | BranchTaken;
  assign target_raw = Jump ? JumpTarget : BranchTarget;
  assign target     = target_raw & ~32'h0000_0003;
  assign accept     = valid & ~Stall & ~redirect;

  // While stalled the memory re-reads the held word so InstIn stays stable.
  assign Pc           = (Stall & ~redirect) ? pc_tag : pc_reg;
  assign IfId_Inst    = valid ? InstIn : NOP_INST;
  assign IfId_Pc      = pc_tag;
  assign IfId_PcPlus4 = pc_tag + 32'd4;
  assign IfId_Valid   = valid;
  assign FetchCount   = cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_reg <= RESET_PC;
      pc_tag <= RESET_PC;
      valid  <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        cnt <= cnt + CNT_ONE;
      end
      // Redirect squashes the fall-through word arriving this edge.
      if (redirect) begin
        pc_reg <= target;
        pc_tag <= pc_reg;
        valid  <= 1'b0;
      end else if (!Stall) begin
        pc_tag <= pc_reg;
        pc_reg <= pc_reg + 32'd4;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] inst_in;
  logic [31:0] pc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000),
    .COUNT_WIDTH(32)
  ) dut (
    .Clk(clk),
    .Rst_n(rst_n),
    .Stall(stall),
    .BranchTaken(branch_taken),
    .BranchTarget(branch_target),
    .Jump(jump),
    .JumpTarget(jump_target),
    .InstIn(inst_in),
    .Pc(pc),
    .IfId_Inst(ifid_inst),
    .IfId_Pc(ifid_pc),
    .IfId_PcPlus4(ifid_pc_plus4),
    .IfId_Valid(ifid_valid),
    .FetchCount(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with one-cycle registered read: word i holds 0x1000_0000 + i.
  always @(posedge clk) inst_in <= 32'h1000_0000 + (pc >> 2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    stall = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 0;
    #1;
    checks++;
    if (pc !== 32'h0 || ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h4 ||
        ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: pc=%h ifid_pc=%h plus4=%h valid=%b inst=%h cnt=%0d required 0/0/4/0/0/0",
               pc, ifid_pc, ifid_pc_plus4, ifid_valid, ifid_inst, fetch_count);
    end
    rst_n = 1;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ifid_inst !== 32'h1000_0000 + i || ifid_pc !== 4 * i || ifid_valid !== 1'b1 ||
          ifid_pc_plus4 !== 4 * i + 4) begin
        failures++;
        $display("FAIL seq_fetch_%0d: inst=%h pc=%h plus4=%h valid=%b required inst=%h pc=%h",
                 i, ifid_inst, ifid_pc, ifid_pc_plus4, ifid_valid, 32'h1000_0000 + i, 4 * i);
      end
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL seq_count: got %0d required 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (3) tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc !== 32'h8 || ifid_pc !== 32'h8 || ifid_inst !== 32'h1000_0002 ||
          fetch_count !== 32'd2 || ifid_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold_%0d: pc=%h ifid_pc=%h inst=%h cnt=%0d valid=%b required 8/8/10000002/2/1",
                 i, pc, ifid_pc, ifid_inst, fetch_count, ifid_valid);
      end
      tick();
    end
    stall = 0;
    tick();
    checks++;
    if (ifid_pc !== 32'hC || ifid_inst !== 32'h1000_0003 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL stall_release: pc=%h inst=%h cnt=%0d required c/10000003/3",
               ifid_pc, ifid_inst, fetch_count);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    repeat (2) tick();
    branch_taken = 1; branch_target = 32'h40;
    tick();
    branch_taken = 0; branch_target = 0;
    checks++;
    if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin
      failures++;
      $display("FAIL branch_bubble: valid=%b inst=%h required 0/0", ifid_valid, ifid_inst);
    end
    tick();
    checks++;
    if (ifid_pc !== 32'h40 || ifid_inst !== 32'h1000_0010 || ifid_valid !== 1'b1 ||
        fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL branch_resume: pc=%h inst=%h valid=%b cnt=%0d required 40/10000010/1/1",
               ifid_pc, ifid_inst, ifid_valid, fetch_count);
    end
  endtask

  task automatic test_jump_priority();
    apply_reset();
    repeat (2) tick();
    jump = 1; jump_target = 32'h83;
    branch_taken = 1; branch_target = 32'h20;
    tick();
    jump = 0; branch_taken = 0;
    checks++;
    if (ifid_valid !== 1'b0 || pc !== 32'h80) begin
      failures++;
      $display("FAIL jump_bubble: valid=%b pc=%h required 0/80", ifid_valid, pc);
    end
    tick();
    checks++;
    if (ifid_pc !== 32'h80 || ifid_inst !== 32'h1000_0020 || ifid_valid !== 1'b1 || pc !== 32'h84) begin
      failures++;
      $display("FAIL jump_resume: ifid_pc=%h inst=%h valid=%b pc=%h required 80/10000020/1/84",
               ifid_pc, ifid_inst, ifid_valid, pc);
    end
  endtask

  task automatic test_redirect_in_stall();
    apply_reset();
    repeat (3) tick();
    stall = 1; branch_taken = 1; branch_target = 32'h10;
    #1;
    checks++;
    if (pc !== 32'hC) begin
      failures++;
      $display("FAIL redirect_stall_pc: got %h required c", pc);
    end
    tick();
    branch_taken = 0;
    checks++;
    if (ifid_valid !== 1'b0 || fetch_count !== 32'd2) begin
      failures++;
      $display("FAIL redirect_stall_bubble: valid=%b cnt=%0d required 0/2", ifid_valid, fetch_count);
    end
    tick();
    checks++;
    if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || fetch_count !== 32'd2) begin
      failures++;
      $display("FAIL stall_on_bubble: valid=%b inst=%h cnt=%0d required 0/0/2",
               ifid_valid, ifid_inst, fetch_count);
    end
    stall = 0;
    tick();
    checks++;
    if (ifid_pc !== 32'h10 || ifid_valid !== 1'b1 || ifid_inst !== 32'h1000_0004 ||
        fetch_count !== 32'd2) begin
      failures++;
      $display("FAIL redirect_stall_resume: pc=%h valid=%b inst=%h cnt=%0d required 10/1/10000004/2",
               ifid_pc, ifid_valid, ifid_inst, fetch_count);
    end
    tick();
    checks++;
    if (ifid_pc !== 32'h14 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL redirect_stall_next: pc=%h cnt=%0d required 14/3", ifid_pc, fetch_count);
    end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    tick();
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 0;
    tick();
    checks++;
    if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc_plus4 !== 32'h0 || pc !== 32'h0 ||
        ifid_inst !== 32'h4FFF_FFFF) begin
      failures++;
      $display("FAIL pc_wrap: ifid_pc=%h plus4=%h pc=%h inst=%h required fffffffc/0/0/4fffffff",
               ifid_pc, ifid_pc_plus4, pc, ifid_inst);
    end
    tick();
    checks++;
    if (ifid_pc !== 32'h0 || ifid_inst !== 32'h1000_0000) begin
      failures++;
      $display("FAIL pc_wrap_next: ifid_pc=%h inst=%h required 0/10000000", ifid_pc, ifid_inst);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (10) tick();
    checks++;
    if (ifid_pc !== 32'h24 || fetch_count !== 32'd9) begin
      failures++;
      $display("FAIL pre_reset: ifid_pc=%h cnt=%0d required 24/9", ifid_pc, fetch_count);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (pc !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'h0 || ifid_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: pc=%h valid=%b cnt=%0d ifid_pc=%h required 0/0/0/0",
               pc, ifid_valid, fetch_count, ifid_pc);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    checks++;
    if (ifid_pc !== 32'h0 || ifid_inst !== 32'h1000_0000 || ifid_valid !== 1'b1 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_restart: pc=%h inst=%h valid=%b cnt=%0d required 0/10000000/1/0",
               ifid_pc, ifid_inst, ifid_valid, fetch_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_redirect_in_stall();
    test_pc_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
